// File: rtl/sgd_update_seq.sv
// Time-multiplexed SGD weight update: LANES elements per beat over
// SIZE/LANES beats, result held on a valid/ready output until consumed.
module sgd_update_seq #(
   parameter int INPUT_BITWIDTH = 8,
   parameter int BITWIDTH       = 16,
   parameter int SIZE           = 10,
   parameter int LANES          = 2,
   parameter int SHIFT          = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [INPUT_BITWIDTH-1:0]    mu,
   input  logic [INPUT_BITWIDTH*SIZE-1:0] x,
   input  logic [BITWIDTH*SIZE-1:0]     w,
   input  logic [BITWIDTH*SIZE-1:0]     in,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [BITWIDTH*SIZE-1:0]     out,
   output logic                         sat_flag
);

   localparam int BEATS  = SIZE / LANES;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int PW     = BITWIDTH + 2*INPUT_BITWIDTH + 1;

   if (SIZE % LANES != 0) begin : g_bad_size
      $error("SIZE must be a multiple of LANES");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                        state;
   logic [BEAT_W-1:0]             beat;
   logic [INPUT_BITWIDTH-1:0]     mu_q;
   logic [INPUT_BITWIDTH*SIZE-1:0] x_q;
   logic [BITWIDTH*SIZE-1:0]      w_q;
   logic [BITWIDTH*SIZE-1:0]      in_q;

   logic [BITWIDTH-1:0] res [LANES];
   logic [LANES-1:0]    lane_sat;

   localparam logic signed [PW-1:0] MAXV =
      {{(PW-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
   localparam logic signed [PW-1:0] MINV =
      {{(PW-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};

   always_comb begin
      int                         idx;
      logic [BITWIDTH-1:0]        ge;
      logic [BITWIDTH-1:0]        we;
      logic [INPUT_BITWIDTH-1:0]  xe;
      logic signed [PW-1:0]       pm, pg, px, p, d, r;
      idx = 0;
      ge  = '0;
      we  = '0;
      xe  = '0;
      pm  = '0;
      pg  = '0;
      px  = '0;
      p   = '0;
      d   = '0;
      r   = '0;
      lane_sat = '0;
      for (int l = 0; l < LANES; l++) begin
         idx = int'(beat) * LANES + l;
         ge  = in_q[BITWIDTH*idx +: BITWIDTH];
         we  = w_q[BITWIDTH*idx +: BITWIDTH];
         xe  = x_q[INPUT_BITWIDTH*idx +: INPUT_BITWIDTH];
         pm  = PW'($signed({1'b0, mu_q}));
         pg  = PW'($signed(ge));
         px  = PW'($signed(xe));
         p   = pm * pg * px;
         // Arithmetic shift floors toward -inf, so small negatives stay -1
         d   = p >>> SHIFT;
         r   = PW'($signed(we)) - d;
         if (r > MAXV) begin
            res[l]      = {1'b0, {(BITWIDTH-1){1'b1}}};
            lane_sat[l] = 1'b1;
         end else if (r < MINV) begin
            res[l]      = {1'b1, {(BITWIDTH-1){1'b0}}};
            lane_sat[l] = 1'b1;
         end else begin
            res[l] = r[BITWIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         beat      <= '0;
         mu_q      <= '0;
         x_q       <= '0;
         w_q       <= '0;
         in_q      <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out       <= '0;
         sat_flag  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  mu_q     <= mu;
                  x_q      <= x;
                  w_q      <= w;
                  in_q     <= in;
                  sat_flag <= 1'b0;
                  beat     <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               for (int l = 0; l < LANES; l++)
                  out[BITWIDTH*(int'(beat)*LANES+l) +: BITWIDTH] <= res[l];
               if (|lane_sat)
                  sat_flag <= 1'b1;
               if (beat == BEAT_W'(BEATS-1)) begin
                  beat      <= '0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  beat <= beat + BEAT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
